// File: rtl/mode_register.sv
// rtl/mode_register.sv - multi-mode register: load, inc/dec, shift left/right, fixed priority
// Optional MODE_REGISTER_SAT_EN: inc/dec saturate instead of rolling over.
module mode_register #(
  parameter int          WIDTH       = 16,
  parameter logic [63:0] RESET_VALUE = 64'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic             shl,
  input  logic             shr,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out,
  output logic             serial_out,
  output logic             zero,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] out_next;
  logic             serial_next;
  logic             wrap_next;
  logic             all_ones;
  logic             all_zero;

  assign all_ones = &out;
  assign all_zero = ~|out;
  assign zero     = all_zero;

  // Priority chain: each branch excludes every lower-priority request.
  always_comb begin
    out_next    = out;
    serial_next = serial_out;
    wrap_next   = 1'b0;
    if (load) begin
      out_next = in;
    end else if (inc) begin
      wrap_next = all_ones;
`ifdef MODE_REGISTER_SAT_EN
      out_next  = all_ones ? out : out + ONE;
`else
      out_next  = out + ONE;
`endif
    end else if (dec) begin
      wrap_next = all_zero;
`ifdef MODE_REGISTER_SAT_EN
      out_next  = all_zero ? out : out - ONE;
`else
      out_next  = out - ONE;
`endif
    end else if (shl) begin
      out_next    = {out[WIDTH-2:0], serial_in};
      serial_next = out[WIDTH-1];
    end else if (shr) begin
      out_next    = {serial_in, out[WIDTH-1:1]};
      serial_next = out[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= RST_VAL;
      serial_out <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      out        <= out_next;
      serial_out <= serial_next;
      wrap       <= wrap_next;
    end
  end

endmodule

// File: doc/mode_register.md
MODE_REGISTER -- requirements
Module: mode_register

Interface
REQ-001 Parameter: WIDTH, default 16, data width in bits; legal range 2..64.
REQ-002 Parameter: RESET_VALUE, default 0, value loaded into out on reset; truncated to WIDTH bits.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port: in  input  WIDTH  parallel load data.
REQ-006 Port: load  input  1  parallel load request.
REQ-007 Port: inc  input  1  increment-by-one request.
REQ-008 Port: dec  input  1  decrement-by-one request.
REQ-009 Port: shl  input  1  shift-left request; serial_in enters at bit 0.
REQ-010 Port: shr  input  1  shift-right request; serial_in enters at bit WIDTH-1.
REQ-011 Port: serial_in  input  1  fill bit for shifts.
REQ-012 Port: out  output  WIDTH  registered contents.
REQ-013 Port: serial_out  output  1  bit shifted out by the last shift op, registered; 0 otherwise.
REQ-014 Port: zero  output  1  combinational, 1 iff out == 0.
REQ-015 Port: wrap  output  1  registered one-cycle pulse on inc/dec boundary event.

Function
REQ-016 One operation per rising edge, fixed priority: reset > load > inc > dec > shl > shr > hold.
REQ-017 Lower-priority requests asserted in the same cycle as a higher one SHALL be ignored, with no side effect.
REQ-018 load: out <= in; takes effect on the same edge and is visible after it (1-cycle latency, as the basic register).
REQ-019 inc: out <= out + 1 modulo 2^WIDTH; dec: out <= out - 1 modulo 2^WIDTH (macro off).
REQ-020 shl: out <= {out[WIDTH-2:0], serial_in}, serial_out <= out[WIDTH-1].
REQ-021 shr: out <= {serial_in, out[WIDTH-1:1]}, serial_out <= out[0].
REQ-022 serial_out SHALL hold its value on non-shift cycles other than reset.
REQ-023 wrap SHALL be 1 for exactly the cycle after an edge where inc acted on all-ones or dec acted on zero; otherwise 0.
REQ-024 Hold (no request): out, serial_out unchanged; wrap <= 0.
REQ-025 No internal state other than out, serial_out, wrap.

Reset
REQ-026 On reset edge: out <= RESET_VALUE, serial_out <= 0, wrap <= 0, regardless of any other input.
REQ-027 reset asserted mid-sequence SHALL abort any op in that cycle; the op is not retried.
REQ-028 Before first reset, outputs are undefined; bench SHALL not check them.

Configuration
REQ-029 Macro MODE_REGISTER_SAT_EN defined: inc on all-ones leaves out at all-ones; dec on zero leaves out at zero; wrap pulses on that saturation event.
REQ-030 Macro MODE_REGISTER_SAT_EN undefined: modulo arithmetic per REQ-019; wrap pulses on rollover.
REQ-031 Load, shift, reset behaviour SHALL be identical with and without the macro.

Verification
REQ-032 WIDTH=16, reset=1 one edge -> out=0x0000, zero=1, wrap=0, serial_out=0.
REQ-033 load=1 in=0xFFFF; next edge load=0 in=0x1234 -> out=0xFFFF after first edge, still 0xFFFF after second.
REQ-034 out=0xFFFF, inc=1 one edge -> out=0x0000, wrap=1 for one cycle, zero=1 (SAT_EN: out=0xFFFF, wrap=1, zero=0).
REQ-035 out=0x8001, shl=1 serial_in=0 -> out=0x0002, serial_out=1; then shr=1 serial_in=1 -> out=0x8001, serial_out=0.
REQ-036 load=1 inc=1 dec=1 in=0x00AA simultaneously -> out=0x00AA, wrap=0.
REQ-037 out=0x0005, inc=1 and reset=1 same edge, RESET_VALUE=0x0003 -> out=0x0003, wrap=0.
